decode_stage_mp: RTL and testbench
==================================

Name: decode_stage_mp

Overview:
Parametrised successor to the single-port decode stage.
- Decodes the fixed 32-bit instruction format and reads operands from an internal multi-write-port register file.
- Detects load-use hazards against the instruction it currently holds and inserts a bubble on a hit.
- Sits between fetch and execute. The stage fields are carried on explicit ports so that widths can be parametrised.

Parameters:
XLEN, 32, data width of registers and operands
NREGS, 256, architectural register count (2..256); index field stays 8 bits
NWB, 2, number of write-back ports (1..4)
R0_ZERO, 1, when 1 register 0 reads as 0 and ignores writes

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall  in  1  hold ID register (pipeline freeze)
flush  in  1  replace next ID content with bubble
if_valid  in  1  IF slot holds a real instruction
if_instruction  in  32  [31:24] op, [23:16] rw, [15:8] r1, [7:0] r2, [15:0] imm
if_pc  in  XLEN  PC of IF instruction
wb_we  in  NWB  per-port write enable
wb_rw  in  NWB*8  per-port destination index, port k at [8k+7:8k]
wb_data  in  NWB*XLEN  per-port write data
id_valid  out  1  ID slot valid
id_pc  out  XLEN  registered PC
id_operation  out  8  registered opcode
id_rw, id_r1, id_r2  out  8 each  registered register fields
id_imm  out  16  registered immediate
id_v1, id_v2  out  XLEN  registered operands
hazard_stall  out  1  combinational; upstream must hold IF this cycle

Behaviour:
- Reset: every output register clears to 0, including id_valid. Register file contents clear to 0. A reset asserted mid-stall also wins.
- Priority per cycle: reset > stall > hazard > flush > normal.
- stall=1: all id_* registers hold their values. No register-file read capture. Writes still commit. hazard_stall forced to 0.
- Normal (no stall, no flush, no hazard):
  - Latch fields from if_instruction and if_pc.
  - id_valid <= if_valid.
  - Latency is 1 cycle IF to ID.
- Operand select:
  - Op in READ_SET {ADD, SUB, AND, WRL, RDL}: v1/v2 come from register file[r1]/[r2].
  - Otherwise: v1/v2 are r1/r2 zero-extended to XLEN.
- Register read rules:
  - Index >= NREGS reads 0.
  - Index 0 reads 0 when R0_ZERO=1.
- Write commit: on rising edge for each port with wb_we set and index < NREGS. Writes to index 0 are dropped when R0_ZERO=1.
- Same index on multiple ports in one cycle: highest port number wins.
- Hazard:
  - Condition: if_valid && !stall && id_valid && id_operation==RDL && id_rw!=0 && incoming op in READ_SET && (r1==id_rw || r2==id_rw).
  - Effect: hazard_stall=1 and the ID register loads a bubble (id_valid=0, all fields 0). IF must hold, so the same instruction is re-presented next cycle; the hazard then clears because ID now holds a bubble.
- flush=1 without stall: ID loads a bubble (id_valid=0, all fields 0).
- if_valid=0: ID loads a bubble and hazard_stall=0.

Optional Feature:
DECODE_BYPASS_EN
- Defined: a read whose index matches an enabled write port in the same cycle returns that wb_data, highest port wins, so the operand is correct in the same cycle.
- Undefined: reads return the pre-edge register contents. The upstream scheduler guarantees one cycle of write-to-read separation.
- Both builds: register file contents after the edge are identical.

Decomposition:
- Shared package `decode_pkg`:
  - opcode constants (ADD, SUB, AND, WRL, RDL, ...)
  - field slice localparams
  - function `reads_regs(op)` implementing READ_SET
  - typedef `t_id_fields`
- Sub-module `regfile_mp`: NREGS x XLEN, NWB write ports, 2 combinational read ports, owns the R0_ZERO and bypass logic.
- Top level holds hazard detection and the ID register.

Test Plan:
- Reset, then wb port0 writes r5=0x11 and port1 writes r5=0x22 in the same cycle; next cycle issue ADD rw=1,r1=5,r2=0 -> id_v1=0x22, id_v2=0.
- Issue RDL rw=3 then ADD r1=3 back-to-back -> cycle 2 hazard_stall=1 and id_valid=0; cycle 3 ADD latched with id_valid=1 and hazard_stall=0.
- With DECODE_BYPASS_EN, write r7=0xDEAD and issue ADD r1=7 in the same cycle -> id_v1=0xDEAD. Without it -> id_v1 equals the old r7 value.
- Non-READ_SET op with r1=0x12, r2=0x34 -> id_v1=0x12, id_v2=0x34 zero-extended. Same instruction with stall=1 -> all id_* unchanged.
- stall=1 and flush=1 together -> ID holds. Release stall with flush=1 -> id_valid=0 and all fields 0.
- NREGS=16: read r1=20 -> 0. Write r0 with R0_ZERO=1, then read r0 -> 0. Assert reset during a hazard -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// ============================================================================
// Package : decode_pkg
// Brief   : Opcodes, instruction field slices and ID field record shared by
//           the multi-port decode stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package decode_pkg;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;
  localparam logic [7:0] OP_WRL = 8'h04;
  localparam logic [7:0] OP_RDL = 8'h05;
  localparam logic [7:0] OP_LDI = 8'h10;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 24;
  localparam int RW_HI  = 23;
  localparam int RW_LO  = 16;
  localparam int R1_HI  = 15;
  localparam int R1_LO  = 8;
  localparam int R2_HI  = 7;
  localparam int R2_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [7:0]  rw;
    logic [7:0]  r1;
    logic [7:0]  r2;
    logic [15:0] imm;
  } t_id_fields;

  function automatic logic reads_regs(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_WRL) || (op == OP_RDL);
  endfunction

  function automatic t_id_fields split_instr(input logic [31:0] instr);
    t_id_fields f;
    f.op  = instr[OP_HI:OP_LO];
    f.rw  = instr[RW_HI:RW_LO];
    f.r1  = instr[R1_HI:R1_LO];
    f.r2  = instr[R2_HI:R2_LO];
    f.imm = instr[IMM_HI:IMM_LO];
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module  : regfile_mp
// Brief   : NREGS x XLEN register file, NWB write ports, two combinational
//           read ports. Same-cycle write forwarding when DECODE_BYPASS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mp
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 256,
  parameter int NWB     = 2,
  parameter int R0_ZERO = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NWB-1:0]        wb_we,
  input  logic [NWB*8-1:0]      wb_rw,
  input  logic [NWB*XLEN-1:0]   wb_data,
  input  logic [7:0]            rd_idx1,
  input  logic [7:0]            rd_idx2,
  output logic [XLEN-1:0]       rd_data1,
  output logic [XLEN-1:0]       rd_data2
);

  localparam int c_ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [XLEN-1:0] r_mem [NREGS];
  logic [NWB-1:0]  w_we_ok;
  logic [1:0][7:0]      w_rd_idx;
  logic [1:0][XLEN-1:0] w_rd_data;

  assign w_rd_idx[0] = rd_idx1;
  assign w_rd_idx[1] = rd_idx2;
  assign rd_data1    = w_rd_data[0];
  assign rd_data2    = w_rd_data[1];

  // A port only counts as a write when it would actually change storage.
  generate
    for (genvar k = 0; k < NWB; k++) begin : g_we
      assign w_we_ok[k] = wb_we[k] && (32'(wb_rw[k*8 +: 8]) < NREGS) &&
                          !((R0_ZERO != 0) && (wb_rw[k*8 +: 8] == 8'd0));
    end
  endgenerate

  // Later loop iterations override earlier ones: highest port wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else begin
      for (int k = 0; k < NWB; k++) begin
        if (w_we_ok[k]) r_mem[wb_rw[k*8 +: c_ADDR_W]] <= wb_data[k*XLEN +: XLEN];
      end
    end
  end

  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd
      always_comb begin
        w_rd_data[p] = '0;
        if ((32'(w_rd_idx[p]) < NREGS) &&
            !((R0_ZERO != 0) && (w_rd_idx[p] == 8'd0))) begin
          w_rd_data[p] = r_mem[w_rd_idx[p][c_ADDR_W-1:0]];
`ifdef DECODE_BYPASS_EN
          for (int k = 0; k < NWB; k++) begin
            if (w_we_ok[k] && (wb_rw[k*8 +: 8] == w_rd_idx[p]))
              w_rd_data[p] = wb_data[k*XLEN +: XLEN];
          end
`endif
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/decode_stage_mp.sv
// ============================================================================
// Module  : decode_stage_mp
// Brief   : Parametrised decode stage: ID register, operand select and
//           load-use hazard bubble. Optional macro DECODE_BYPASS_EN enables
//           same-cycle write-back forwarding in the register file.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_stage_mp
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 256,
  parameter int NWB     = 2,
  parameter int R0_ZERO = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                if_valid,
  input  logic [31:0]         if_instruction,
  input  logic [XLEN-1:0]     if_pc,
  input  logic [NWB-1:0]      wb_we,
  input  logic [NWB*8-1:0]    wb_rw,
  input  logic [NWB*XLEN-1:0] wb_data,
  output logic                id_valid,
  output logic [XLEN-1:0]     id_pc,
  output logic [7:0]          id_operation,
  output logic [7:0]          id_rw,
  output logic [7:0]          id_r1,
  output logic [7:0]          id_r2,
  output logic [15:0]         id_imm,
  output logic [XLEN-1:0]     id_v1,
  output logic [XLEN-1:0]     id_v2,
  output logic                hazard_stall
);

  t_id_fields      w_if;
  logic [XLEN-1:0] w_rf1;
  logic [XLEN-1:0] w_rf2;
  logic            w_if_reads;
  logic            w_hazard;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  t_id_fields      r_f;
  logic [XLEN-1:0] r_v1;
  logic [XLEN-1:0] r_v2;

  assign w_if       = split_instr(if_instruction);
  assign w_if_reads = reads_regs(w_if.op);

  regfile_mp #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .NWB     (NWB),
    .R0_ZERO (R0_ZERO)
  ) u_regfile (
    .clock    (clock),
    .reset    (reset),
    .wb_we    (wb_we),
    .wb_rw    (wb_rw),
    .wb_data  (wb_data),
    .rd_idx1  (w_if.r1),
    .rd_idx2  (w_if.r2),
    .rd_data1 (w_rf1),
    .rd_data2 (w_rf2)
  );

  // Load-use: the load in ID has not produced its value yet.
  assign w_hazard = !reset && if_valid && !stall && r_valid &&
                    (r_f.op == OP_RDL) && (r_f.rw != 8'd0) && w_if_reads &&
                    ((w_if.r1 == r_f.rw) || (w_if.r2 == r_f.rw));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_f     <= '0;
      r_v1    <= '0;
      r_v2    <= '0;
    end else if (stall) begin
      r_valid <= r_valid;
    end else if (w_hazard || flush || !if_valid) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_f     <= '0;
      r_v1    <= '0;
      r_v2    <= '0;
    end else begin
      r_valid <= 1'b1;
      r_pc    <= if_pc;
      r_f     <= w_if;
      r_v1    <= w_if_reads ? w_rf1 : XLEN'(w_if.r1);
      r_v2    <= w_if_reads ? w_rf2 : XLEN'(w_if.r2);
    end
  end

  assign id_valid     = r_valid;
  assign id_pc        = r_pc;
  assign id_operation = r_f.op;
  assign id_rw        = r_f.rw;
  assign id_r1        = r_f.r1;
  assign id_r2        = r_f.r2;
  assign id_imm       = r_f.imm;
  assign id_v1        = r_v1;
  assign id_v2        = r_v2;
  assign hazard_stall = w_hazard;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_mp.sv
// Bench for decode_stage_mp (NREGS=16, NWB=2): directed plan steps, then random traffic vs a reference model.
`default_nettype none

module tb_decode_stage_mp;
  import decode_pkg::*;

  logic        clock = 1'b0;
  logic        reset, stall, flush, if_valid;
  logic [31:0] if_instruction, if_pc;
  logic [1:0]  wb_we;
  logic [15:0] wb_rw;
  logic [63:0] wb_data;
  logic        id_valid, hazard_stall;
  logic [31:0] id_pc, id_v1, id_v2;
  logic [7:0]  id_operation, id_rw, id_r1, id_r2;
  logic [15:0] id_imm;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [31:0] ref_rf [16];
  logic        m_valid;
  logic [31:0] m_pc, m_v1, m_v2;
  logic [7:0]  m_op, m_rw, m_r1, m_r2;
  logic [15:0] m_imm;

  decode_stage_mp #(.XLEN(32), .NREGS(16), .NWB(2), .R0_ZERO(1)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc),
    .wb_we(wb_we), .wb_rw(wb_rw), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_operation(id_operation),
    .id_rw(id_rw), .id_r1(id_r1), .id_r2(id_r2), .id_imm(id_imm),
    .id_v1(id_v1), .id_v2(id_v2), .hazard_stall(hazard_stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_read_set(input logic [7:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_WRL, OP_RDL};
  endfunction

  // Architectural read as seen during the current cycle.
  function automatic logic [31:0] mread(input logic [7:0] idx);
    logic [31:0] v;
    if (idx >= 8'd16 || idx == 8'd0) return 32'd0;
    v = ref_rf[idx[3:0]];
`ifdef DECODE_BYPASS_EN
    for (int k = 0; k < 2; k++)
      if (wb_we[k] && wb_rw[k*8 +: 8] == idx) v = wb_data[k*32 +: 32];
`endif
    return v;
  endfunction

  task automatic bubble_model();
    m_valid = 0; m_pc = 0; m_op = 0; m_rw = 0; m_r1 = 0; m_r2 = 0;
    m_imm = 0; m_v1 = 0; m_v2 = 0;
  endtask

  // One clock: check hazard before the edge, advance model, check ID after.
  task automatic tick();
    logic       exp_hz;
    logic [7:0] op, rw, r1, r2;
    #1;
    op = if_instruction[31:24]; rw = if_instruction[23:16];
    r1 = if_instruction[15:8];  r2 = if_instruction[7:0];
    exp_hz = !reset && if_valid && !stall && m_valid && m_op == OP_RDL &&
             m_rw != 0 && in_read_set(op) && (r1 == m_rw || r2 == m_rw);
    chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, exp_hz});
    if (reset) begin
      bubble_model();
      for (int i = 0; i < 16; i++) ref_rf[i] = 0;
    end else begin
      if (!stall) begin
        if (exp_hz || flush || !if_valid) bubble_model();
        else begin
          m_valid = 1; m_pc = if_pc; m_op = op; m_rw = rw; m_r1 = r1; m_r2 = r2;
          m_imm = if_instruction[15:0];
          m_v1 = in_read_set(op) ? mread(r1) : {24'd0, r1};
          m_v2 = in_read_set(op) ? mread(r2) : {24'd0, r2};
        end
      end
      for (int k = 0; k < 2; k++) begin
        logic [7:0] w;
        w = wb_rw[k*8 +: 8];
        if (wb_we[k] && w < 8'd16 && w != 8'd0) ref_rf[w[3:0]] = wb_data[k*32 +: 32];
      end
    end
    @(posedge clock);
    #1;
    chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
    chk("id_pc", id_pc, m_pc);
    chk("id_operation", {24'd0, id_operation}, {24'd0, m_op});
    chk("id_rw", {24'd0, id_rw}, {24'd0, m_rw});
    chk("id_r1", {24'd0, id_r1}, {24'd0, m_r1});
    chk("id_r2", {24'd0, id_r2}, {24'd0, m_r2});
    chk("id_imm", {16'd0, id_imm}, {16'd0, m_imm});
    chk("id_v1", id_v1, m_v1);
    chk("id_v2", id_v2, m_v2);
  endtask

  task automatic issue(input logic [7:0] op, input logic [7:0] rw,
                       input logic [7:0] r1, input logic [7:0] r2);
    if_valid = 1;
    if_instruction = {op, rw, r1, r2};
    if_pc = if_pc + 32'd4;
  endtask

  logic [7:0] oplist [8];

  initial begin
    oplist = '{OP_ADD, OP_SUB, OP_AND, OP_WRL, OP_RDL, OP_NOP, OP_LDI, 8'hFF};
    bubble_model();
    for (int i = 0; i < 16; i++) ref_rf[i] = 0;
    reset = 1; stall = 0; flush = 0; if_valid = 0;
    if_instruction = 0; if_pc = 32'h100; wb_we = 0; wb_rw = 0; wb_data = 0;

    // reset state
    tick(); tick();
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_v1", id_v1, 32'd0);
    reset = 0;

    // two ports write r5 in one cycle: port 1 wins
    wb_we = 2'b11; wb_rw = {8'd5, 8'd5}; wb_data = {32'h22, 32'h11};
    tick();
    wb_we = 0;
    issue(OP_ADD, 8'd1, 8'd5, 8'd0);
    tick();
    chk("plan_multiwrite_v1", id_v1, 32'h22);
    chk("plan_multiwrite_v2", id_v2, 32'h0);

    // load-use hazard then replay
    issue(OP_RDL, 8'd3, 8'd0, 8'd0);
    tick();
    issue(OP_ADD, 8'd4, 8'd3, 8'd0);
    #1 chk("plan_hazard_hi", {31'd0, hazard_stall}, 32'd1);
    tick();
    chk("plan_hazard_bubble", {31'd0, id_valid}, 32'd0);
    #1 chk("plan_hazard_clear", {31'd0, hazard_stall}, 32'd0);
    tick();
    chk("plan_replay_valid", {31'd0, id_valid}, 32'd1);
    chk("plan_replay_op", {24'd0, id_operation}, {24'd0, OP_ADD});

    // same-cycle write vs read of r7
    if_valid = 0; wb_we = 2'b01; wb_rw = {8'd0, 8'd7}; wb_data = {32'd0, 32'h1234};
    tick();
    wb_data = {32'd0, 32'hDEAD};
    issue(OP_ADD, 8'd2, 8'd7, 8'd0);
    tick();
    wb_we = 0;
`ifdef DECODE_BYPASS_EN
    chk("plan_bypass_v1", id_v1, 32'hDEAD);
`else
    chk("plan_nobypass_v1", id_v1, 32'h1234);
`endif

    // non read-set op zero-extends fields; stall holds
    issue(OP_LDI, 8'd9, 8'h12, 8'h34);
    tick();
    chk("plan_zext_v1", id_v1, 32'h12);
    chk("plan_zext_v2", id_v2, 32'h34);
    stall = 1;
    issue(OP_SUB, 8'd1, 8'd2, 8'd3);
    tick();
    chk("plan_stall_op", {24'd0, id_operation}, {24'd0, OP_LDI});
    chk("plan_stall_v1", id_v1, 32'h12);

    // stall + flush holds; flush alone bubbles
    flush = 1;
    tick();
    chk("plan_stallflush_valid", {31'd0, id_valid}, 32'd1);
    stall = 0;
    tick();
    chk("plan_flush_valid", {31'd0, id_valid}, 32'd0);
    chk("plan_flush_op", {24'd0, id_operation}, 32'd0);
    chk("plan_flush_v1", id_v1, 32'd0);
    flush = 0;

    // out-of-range index and r0 write
    issue(OP_ADD, 8'd1, 8'd20, 8'd0);
    wb_we = 2'b01; wb_rw = {8'd0, 8'd0}; wb_data = {32'd0, 32'h55};
    tick();
    chk("plan_oob_v1", id_v1, 32'd0);
    wb_we = 0;
    issue(OP_ADD, 8'd1, 8'd0, 8'd0);
    tick();
    chk("plan_r0_v1", id_v1, 32'd0);

    // reset during a hazard
    issue(OP_RDL, 8'd3, 8'd1, 8'd1);
    tick();
    issue(OP_ADD, 8'd4, 8'd3, 8'd3);
    reset = 1;
    tick();
    chk("plan_rst_hz_valid", {31'd0, id_valid}, 32'd0);
    chk("plan_rst_hz_pc", id_pc, 32'd0);
    chk("plan_rst_hz_op", {24'd0, id_operation}, 32'd0);
    reset = 0;

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 49) == 0);
      stall    = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 7) == 0);
      if_valid = ($urandom_range(0, 7) != 0);
      if_instruction = {oplist[$urandom_range(0, 7)], 8'($urandom_range(0, 5)),
                        8'($urandom_range(0, 19)), 8'($urandom_range(0, 19))};
      if_pc   = $urandom;
      wb_we   = 2'($urandom_range(0, 3));
      wb_rw   = {8'($urandom_range(0, 18)), 8'($urandom_range(0, 18))};
      wb_data = {$urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
